// File: rtl/trap_sched.sv
// Machine-mode trap entry sequencer: prioritises exceptions and interrupts, drains the
// pipeline, then issues a single-cycle trap command with cause, tval and epc.
module trap_sched #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned FLUSH_TMO = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            retire_valid_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic            msip_i,
  input  logic            mtip_i,
  input  logic            meip_i,
  output logic            flush_req_o,
  input  logic            flush_ack_i,
  output logic            stall_o,
  output logic            trap_valid_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic [XLEN-1:0] trap_tval_o,
  output logic [XLEN-1:0] trap_epc_o,
  output logic [XLEN-1:0] mip_o
);

  localparam logic [7:0] TmoMax = 8'(FLUSH_TMO);

  typedef enum logic [1:0] {StIdle, StDrain, StTake, StSettle} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [7:0]        tmo_q, tmo_d;

  logic [XLEN-1:0]   pend;
  logic              int_ok;
  logic [3:0]        int_code;
  logic [XLEN-1:0]   int_cause;
  logic [XLEN-1:0]   exc_cause_ext;

  always_comb begin
    mip_o     = '0;
    mip_o[3]  = msip_i;
    mip_o[7]  = mtip_i;
    mip_o[11] = meip_i;
  end

  assign pend   = mip_o & mie_i;
  assign int_ok = mstatus_mie_i & (|pend);

  // MEI > MSI > MTI
  always_comb begin
    if (pend[11]) begin
      int_code = 4'd11;
    end else if (pend[3]) begin
      int_code = 4'd3;
    end else begin
      int_code = 4'd7;
    end
  end

  assign int_cause     = {1'b1, {(XLEN-5){1'b0}}, int_code};
  assign exc_cause_ext = {{(XLEN-4){1'b0}}, exc_cause_i};

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    epc_d   = epc_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (exc_valid_i) begin
          cause_d = exc_cause_ext;
          tval_d  = exc_tval_i;
          epc_d   = exc_pc_i;
          tmo_d   = '0;
          state_d = StDrain;
        end else if (int_ok && retire_valid_i) begin
          cause_d = int_cause;
          tval_d  = '0;
          epc_d   = next_pc_i;
          tmo_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // An exception from an older instruction displaces a latched interrupt only.
        if (exc_valid_i && cause_q[XLEN-1]) begin
          cause_d = exc_cause_ext;
          tval_d  = exc_tval_i;
          epc_d   = exc_pc_i;
        end
        if (tmo_q != TmoMax) begin
          tmo_d = tmo_q + 8'd1;
        end
        if (flush_ack_i || (tmo_q == TmoMax)) begin
          state_d = StTake;
        end
      end
      StTake:   state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cause_q <= '0;
      tval_q  <= '0;
      epc_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      epc_q   <= epc_d;
      tmo_q   <= tmo_d;
    end
  end

  assign flush_req_o  = (state_q == StDrain);
  assign stall_o      = (state_q != StIdle);
  assign trap_valid_o = (state_q == StTake);
  assign trap_cause_o = cause_q;
  assign trap_tval_o  = tval_q;
  assign trap_epc_o   = epc_q;

endmodule

// File: tb/tb_trap_sched.sv
// Bench for trap_sched: directed scenarios plus randomized traffic, all checked each cycle
// against a phase/age reference model of trap entry.
module tb_trap_sched;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned FLUSH_TMO = 255;

  logic            clk;
  logic            rst_n;
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic [XLEN-1:0] exc_pc;
  logic            retire_valid;
  logic [XLEN-1:0] next_pc;
  logic            mstatus_mie;
  logic [XLEN-1:0] mie;
  logic            msip, mtip, meip;
  logic            flush_req;
  logic            flush_ack;
  logic            stall;
  logic            trap_valid;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic [XLEN-1:0] trap_epc;
  logic [XLEN-1:0] mip;

  int n_vec;
  int n_err;

  // Reference model: phase 0 idle, 1 drain, 2 take, 3 settle.
  int          m_phase;
  int          m_age;
  logic [63:0] m_cause, m_tval, m_epc;

  trap_sched #(.XLEN(XLEN), .FLUSH_TMO(FLUSH_TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exc_valid_i    (exc_valid),
    .exc_cause_i    (exc_cause),
    .exc_tval_i     (exc_tval),
    .exc_pc_i       (exc_pc),
    .retire_valid_i (retire_valid),
    .next_pc_i      (next_pc),
    .mstatus_mie_i  (mstatus_mie),
    .mie_i          (mie),
    .msip_i         (msip),
    .mtip_i         (mtip),
    .meip_i         (meip),
    .flush_req_o    (flush_req),
    .flush_ack_i    (flush_ack),
    .stall_o        (stall),
    .trap_valid_o   (trap_valid),
    .trap_cause_o   (trap_cause),
    .trap_tval_o    (trap_tval),
    .trap_epc_o     (trap_epc),
    .mip_o          (mip)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The pipeline is stalled in TAKE/SETTLE, so no exception may be presented there.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(exc_valid && stall && !flush_req))
        else $error("exc_valid presented while trap entry is past the drain");
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mip();
    logic [63:0] v;
    v = '0;
    if (msip) v = v + 64'h8;
    if (mtip) v = v + 64'h80;
    if (meip) v = v + 64'h800;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_cause = '0;
    m_tval  = '0;
    m_epc   = '0;
  endtask

  task automatic model_step();
    int          prio[3];
    int          code;
    logic [63:0] live;
    prio = '{11, 3, 7};
    code = -1;
    live = ref_mip() & mie;
    if (mstatus_mie) begin
      for (int i = 0; i < 3; i++) begin
        if (code < 0 && live[prio[i]]) code = prio[i];
      end
    end
    case (m_phase)
      0: begin
        if (exc_valid) begin
          m_cause = 64'(exc_cause);
          m_tval  = exc_tval;
          m_epc   = exc_pc;
          m_phase = 1;
          m_age   = 0;
        end else if (code >= 0 && retire_valid) begin
          m_cause = 64'h8000_0000_0000_0000 + 64'(code);
          m_tval  = '0;
          m_epc   = next_pc;
          m_phase = 1;
          m_age   = 0;
        end
      end
      1: begin
        if (exc_valid && m_cause[63]) begin
          m_cause = 64'(exc_cause);
          m_tval  = exc_tval;
          m_epc   = exc_pc;
        end
        if (flush_ack || m_age == FLUSH_TMO) m_phase = 2;
        else m_age++;
      end
      2: m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  // Called at a falling edge with inputs already set: check outputs, advance model one edge.
  task automatic tick();
    #1;
    check_eq("flush_req", 64'(flush_req), 64'(m_phase == 1));
    check_eq("stall", 64'(stall), 64'(m_phase != 0));
    check_eq("trap_valid", 64'(trap_valid), 64'(m_phase == 2));
    check_eq("mip", mip, ref_mip());
    if (m_phase == 2) begin
      check_eq("model_cause", trap_cause, m_cause);
      check_eq("model_tval", trap_tval, m_tval);
      check_eq("model_epc", trap_epc, m_epc);
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic expect_trap(input string tag, input logic [63:0] cause, input logic [63:0] epc,
                             input logic [63:0] tval);
    int k;
    k = 0;
    while (!trap_valid && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      check_eq({tag, "_seen"}, 64'(trap_valid), 64'd1);
    end else begin
      check_eq({tag, "_cause"}, trap_cause, cause);
      check_eq({tag, "_epc"}, trap_epc, epc);
      check_eq({tag, "_tval"}, trap_tval, tval);
      tick();
    end
  endtask

  task automatic quiet();
    exc_valid    = 1'b0;
    retire_valid = 1'b0;
    flush_ack    = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int k;
    int seen;
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_n        = 1'b0;
    exc_valid    = 1'b0;
    exc_cause    = '0;
    exc_tval     = '0;
    exc_pc       = '0;
    retire_valid = 1'b0;
    next_pc      = '0;
    mstatus_mie  = 1'b0;
    mie          = '0;
    msip         = 1'b0;
    mtip         = 1'b0;
    meip         = 1'b0;
    flush_ack    = 1'b0;

    @(negedge clk);
    #1;
    check_eq("rst_flush_req", 64'(flush_req), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_trap_valid", 64'(trap_valid), 64'd0);
    check_eq("rst_cause", trap_cause, 64'd0);
    check_eq("rst_tval", trap_tval, 64'd0);
    check_eq("rst_epc", trap_epc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Exception, ack one cycle after DRAIN entry
    exc_valid = 1'b1;
    exc_cause = 4'd11;
    exc_pc    = 64'h8000_0010;
    exc_tval  = '0;
    flush_ack = 1'b0;
    tick();
    exc_valid = 1'b0;
    flush_ack = 1'b1;
    expect_trap("ecall", 64'h0B, 64'h8000_0010, 64'd0);
    quiet();

    // Interrupt priority and back-to-back traps on later retires
    mstatus_mie  = 1'b1;
    mie          = 64'h888;
    msip         = 1'b1;
    mtip         = 1'b1;
    meip         = 1'b1;
    retire_valid = 1'b1;
    next_pc      = 64'h100;
    expect_trap("irq_mei", 64'h8000_0000_0000_000B, 64'h100, 64'd0);
    meip = 1'b0;
    expect_trap("irq_msi", 64'h8000_0000_0000_0003, 64'h100, 64'd0);
    msip = 1'b0;
    expect_trap("irq_mti", 64'h8000_0000_0000_0007, 64'h100, 64'd0);
    mtip = 1'b0;
    quiet();

    // Masking: globally disabled, then locally disabled
    msip         = 1'b1;
    mtip         = 1'b1;
    meip         = 1'b1;
    retire_valid = 1'b1;
    seen         = 0;
    mstatus_mie  = 1'b0;
    repeat (50) begin
      if (flush_req) seen++;
      tick();
    end
    check_eq("mask_mip", mip, 64'h888);
    mstatus_mie = 1'b1;
    mie         = 64'h0;
    repeat (50) begin
      if (flush_req) seen++;
      tick();
    end
    check_eq("mask_no_flush", 64'(seen), 64'd0);

    // Exception and interrupt together: exception wins
    mie          = 64'h888;
    mtip         = 1'b0;
    meip         = 1'b0;
    next_pc      = 64'h200;
    exc_valid    = 1'b1;
    exc_cause    = 4'd3;
    exc_pc       = 64'h300;
    exc_tval     = 64'h44;
    flush_ack    = 1'b1;
    tick();
    exc_valid    = 1'b0;
    retire_valid = 1'b0;
    expect_trap("simul", 64'h3, 64'h300, 64'h44);
    quiet();

    // Interrupt latched, then an exception in DRAIN replaces it
    retire_valid = 1'b1;
    flush_ack    = 1'b0;
    tick();
    retire_valid = 1'b0;
    exc_valid    = 1'b1;
    exc_cause    = 4'd2;
    exc_pc       = 64'h400;
    exc_tval     = 64'h55;
    tick();
    exc_valid = 1'b0;
    flush_ack = 1'b1;
    expect_trap("override", 64'h2, 64'h400, 64'h55);
    msip = 1'b0;
    quiet();

    // Exception never displaces an exception
    exc_valid = 1'b1;
    exc_cause = 4'd5;
    exc_pc    = 64'h500;
    exc_tval  = 64'h5;
    flush_ack = 1'b0;
    tick();
    exc_cause = 4'd6;
    exc_pc    = 64'h600;
    exc_tval  = 64'h6;
    tick();
    exc_valid = 1'b0;
    flush_ack = 1'b1;
    expect_trap("exc_keep", 64'h5, 64'h500, 64'h5);
    quiet();

    // Drain timeout with no ack
    exc_valid = 1'b1;
    exc_cause = 4'd1;
    exc_pc    = 64'h700;
    exc_tval  = 64'h7;
    flush_ack = 1'b0;
    tick();
    exc_valid = 1'b0;
    k = 0;
    while (!trap_valid && k < 400) begin
      tick();
      k++;
    end
    check_eq("tmo_latency", 64'(k), 64'(FLUSH_TMO + 1));
    check_eq("tmo_cause", trap_cause, 64'h1);
    quiet();

    // Reset asserted mid-DRAIN
    exc_valid = 1'b1;
    exc_cause = 4'd8;
    exc_pc    = 64'h800;
    exc_tval  = 64'h8;
    flush_ack = 1'b0;
    tick();
    exc_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_flush_req", 64'(flush_req), 64'd0);
    check_eq("midrst_stall", 64'(stall), 64'd0);
    check_eq("midrst_trap_valid", 64'(trap_valid), 64'd0);
    check_eq("midrst_cause", trap_cause, 64'd0);
    check_eq("midrst_epc", trap_epc, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    flush_ack = 1'b1;
    repeat (10) tick();

    // Randomized traffic
    repeat (2000) begin
      exc_valid    = (m_phase <= 1) && ($urandom_range(0, 7) == 0);
      exc_cause    = 4'($urandom);
      exc_tval     = {$urandom, $urandom};
      exc_pc       = {$urandom, $urandom};
      retire_valid = 1'($urandom);
      next_pc      = {$urandom, $urandom};
      mstatus_mie  = ($urandom_range(0, 3) != 0);
      mie          = {$urandom, $urandom};
      msip         = ($urandom_range(0, 3) == 0);
      mtip         = ($urandom_range(0, 3) == 0);
      meip         = ($urandom_range(0, 3) == 0);
      flush_ack    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trap_sched.md
Name: trap_sched

Overview:
- Sequences entry into the machine-mode trap path of the CSR/system controller.
- Collects synchronous exceptions from execute and the three machine interrupt sources (software, timer, external), then prioritises them.
- Drains the pipeline with a flush handshake, then issues exactly one single-cycle trap command carrying cause, tval and epc to the CSR/trap logic.
- Sits between execute/retire and system_ctl; owns the trap-entry decision only (mret is untouched).

Parameters:
- XLEN, 64, data/address width; cause MSB = XLEN-1.
- FLUSH_TMO, 255, max DRAIN cycles before forced commit; 8-bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- exc_valid  in  1  synchronous exception from execute this cycle
- exc_cause  in  4  exception code (e.g. 8 = ecall-U, 11 = ecall-M, 3 = ebreak)
- exc_tval  in  XLEN  faulting value
- exc_pc  in  XLEN  pc of faulting instruction
- retire_valid  in  1  an instruction retires this cycle (interrupt boundary)
- next_pc  in  XLEN  pc following the retiring instruction
- mstatus_mie  in  1  global machine interrupt enable
- mie  in  XLEN  interrupt enable CSR; bits 3, 7, 11 used
- msip, mtip, meip  in  1 each  level-sensitive pending sources
- flush_req  out  1  request pipeline drain/flush
- flush_ack  in  1  pipeline empty, flush done
- stall  out  1  hold fetch/issue
- trap_valid  out  1  one-cycle trap command
- trap_cause  out  XLEN  mcause value
- trap_tval  out  XLEN  mtval value
- trap_epc  out  XLEN  mepc value
- mip  out  XLEN  live pending view: bit 3 = msip, 7 = mtip, 11 = meip, others 0

Behaviour:
- Reset (async, rst_n = 0): state IDLE; flush_req, stall, trap_valid = 0; trap_cause, trap_tval, trap_epc = 0; timeout counter = 0. Reset mid-DRAIN/TAKE abandons the trap and emits no trap_valid.
- mip is combinational from the source pins and is not registered.
- Interrupt eligible: int_ok = mstatus_mie & |(mip & mie).
- Interrupt priority: MEI(11) > MSI(3) > MTI(7).
- States: IDLE, DRAIN, TAKE, SETTLE.
- IDLE, exc_valid = 1: latch cause = {0, exc_cause zero-extended}, tval = exc_tval, epc = exc_pc; go to DRAIN next cycle.
- IDLE, else if int_ok & retire_valid: latch cause = {1'b1, code}, tval = 0, epc = next_pc; go to DRAIN.
- IDLE, exception and interrupt in the same cycle: the exception wins and the interrupt stays pending (level).
- DRAIN: flush_req = 1, stall = 1.
  - exc_valid in DRAIN while the latched item is an interrupt: overwrite with the exception (older instruction).
  - An exception never overwrites an exception.
  - flush_ack = 1 → TAKE.
  - Counter reaches FLUSH_TMO → TAKE anyway.
- TAKE: exactly one cycle.
  - trap_valid = 1; trap_cause/tval/epc are driven from the latches and stay stable that cycle.
  - stall = 1, flush_req = 0.
  - Go to SETTLE.
- SETTLE: one cycle, stall = 1, so that system_ctl's MIE clear is visible before int_ok is re-evaluated; go to IDLE.
- trap_cause/tval/epc hold their last value outside TAKE (don't-care to consumers).
- Latency: exception to trap_valid is at least 2 cycles (IDLE→DRAIN, DRAIN→TAKE with flush_ack already high).
- Interrupt pending that deasserts during DRAIN: the trap is still taken with the latched cause (no cancellation).
- exc_valid in TAKE/SETTLE is ignored; the pipeline is stalled so it must not occur. A bench assertion flags it.
- Timeout counter: clears on entering DRAIN, saturates, and does not wrap.

Test Plan:
- Reset mid-op: rst_n = 0 asserted in DRAIN → all outputs 0 immediately, state IDLE, no trap_valid after release.
- Exception: exc_valid = 1, cause = 11, pc = 0x8000_0010, flush_ack one cycle later → trap_valid one cycle with trap_cause = 0x0B, trap_epc = 0x8000_0010, trap_tval = 0; stall high for DRAIN, TAKE and SETTLE.
- Interrupt priority: mstatus_mie = 1, mie = 0x888, mtip = meip = msip = 1, retire_valid with next_pc = 0x100 → trap_cause = 0x8000_0000_0000_000B, epc = 0x100; with meip = 0 → cause LSBs = 3.
- Masking: mstatus_mie = 0 or mie = 0 with all sources pending → no flush_req for 50 cycles; mip reads 0x888.
- Simultaneous/override: exception and interrupt in the same cycle → cause = exception; interrupt latched, then exc_valid during DRAIN → trap_cause becomes the exception code, epc = exc_pc.
- Timeout: flush_ack held 0 → trap_valid exactly FLUSH_TMO+1 cycles after DRAIN entry; back-to-back: sources still pending after SETTLE with mstatus_mie = 1 → second trap taken on the next retire_valid.
